regfile_bist: RTL and testbench
===============================

# regfile_bist

Built-in self-test initiator for the 4×4 `regfile4` register file. On a start command it drives `regfile4`'s write and dual-read ports through a two-pass pattern sequence. It compares both read ports against expected data and reports pass/fail with the first failing address. It sits beside `regfile4` in the datapath and owns its ports only while `busy` is high; the surrounding mux is outside this block.

## Interface
- `DW`, 4: data width; must match `regfile4`
- `AW`, 2: address width; register count is 2**AW = 4
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: level, sampled only in IDLE
- `seed` in DW: base pattern, sampled together with `start`
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle pulse at end of test
- `pass` out 1: test result; valid from `done` until next accepted `start`
- `fail_addr` out AW: address of first mismatch; 0 if none
- `rw` out AW: write address to `regfile4`
- `we` out 1: write enable to `regfile4`
- `wdata` out DW: write data to `regfile4`
- `ra` out AW: read address A to `regfile4`
- `rb` out AW: read address B to `regfile4`
- `rdata_a` in DW: registered read data A from `regfile4`
- `rdata_b` in DW: registered read data B from `regfile4`

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE. Registered index `idx` (AW bits), registered pass bit `ph` (0/1), latched `seed_q`.
- **Pattern:** `pat(i) = (seed_q + i) mod 2**DW` for ph=0, and `~pat(i)` for ph=1. The sum is truncated to DW bits, so it wraps.
- **IDLE:** if `start`=1, then `seed_q<=seed`, `pass<=1`, `fail_addr<=0`, `ph<=0`, `idx<=0`, and go to WRITE.
- **WRITE:** `we=1`, `rw=idx`, `wdata=pat(idx)`. `idx` increments each cycle. After idx=3, reset `idx<=0` and go to READ.
- **READ:** `ra=idx`, `rb=idx^3`. `idx` increments each cycle. After idx=3, go to DRAIN.
- **Compare:** `regfile4` read data appears one cycle after the address. In the cycle after each READ issue (READ idx≥1, or DRAIN), compare `rdata_a` to `pat(prev idx)` and `rdata_b` to `pat(prev idx^3)`.
- **First mismatch:** clears `pass` and loads `fail_addr` with the mismatching register address. Port A wins if both ports mismatch. Later mismatches leave `fail_addr` unchanged.
- **DRAIN:** performs the last compare. If ph=0, set `ph<=1`, `idx<=0` and go to WRITE. If ph=1, go to DONE.
- **DONE:** `done=1` for one cycle, then go to IDLE.
- **Outside WRITE:** `we=0`, `rw=0`, `wdata=0`.
- **Outside READ:** `ra=0`, `rb=0`.
- **Write-before-read:** `regfile4` has no reset and reads return pre-write data in the write cycle. The BIST therefore never reads an address before the WRITE phase that fills it completes.
- **`start` during a run:** ignored while busy. A `start` held high re-launches the test one cycle after DONE (the IDLE cycle).
- **Reset, mid-run included:** asynchronous return to IDLE. `busy`, `done`, `pass`, `we`, `rw`, `wdata`, `ra`, `rb`, `fail_addr` and `idx` are all 0. `regfile4` contents are left indeterminate.

## Timing
- E0 is the edge that accepts `start`. Writes commit at E1–E4 (addresses 0–3). Read addresses are captured by `regfile4` at E5–E8. Compares register at E6–E9.
- Pass 1 writes at E10–E13, captures reads at E14–E17, and compares at E15–E18.
- `done` is high in the cycle E18–E19; IDLE is reached at E19. The whole run is 19 cycles, start to IDLE.
- All outputs decode from registered state; there is no combinational path from `start` or `seed` to any output.
- `pass` and `fail_addr` are stable from E18 until the next accepted `start`.

## Structure
- Shared package `regfile_pkg` holds: `DW`/`AW` defaults, the register count constant, the state enum `bist_state_t`, and the pattern function `pat(seed, idx, ph)`. `regfile4` and this block both use the package.
- No sub-module inside `regfile_bist`: FSM, index counter and comparator form one module (~150–200 lines).
- The testbench instantiates `regfile_bist` directly wired to `regfile4`.

## Test plan
- **Seed 0x5, fault-free `regfile4`:** pass 0 writes 5,6,7,8 and pass 1 writes A,9,8,7 to addresses 0–3. `done` fires at E18 with `pass`=1 and `fail_addr`=0.
- **Seed 0xF, wrap:** writes F,0,1,2 and then 0,F,E,D. Result `pass`=1.
- **Seed 0x5 with `regfile4` reg[2] bit0 forced to 1:** pass 0 is clean. In pass 1 the rb read of addr 2 returns 9 instead of 8, giving `pass`=0 and `fail_addr`=2.
- **Start pulses during a run:** pulse `start` at E3 and at E12. There is no restart, `done` still fires exactly once at E18, and `seed_q` is unchanged.
- **Reset mid-run:** deassert `rst_n` during pass 0 READ. `we`, `busy`, `ra` and `rb` drop to 0 immediately with no `done`. After release, a new `start` with seed 0x3 passes.
- **Back-to-back runs:** hold `start` high. `done` pulses every 20 cycles, and `pass`/`fail_addr` clear at each accept.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for regfile4 and its BIST initiator: sizes, BIST state
// encoding and the test pattern generator.
package regfile_pkg;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int NREGS = 1 << AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  // Pass 0 pattern is seed+idx (wrapping); pass 1 is its bitwise complement
  function automatic logic [DW-1:0] pat(input logic [DW-1:0] seed,
                                        input logic [AW-1:0] idx,
                                        input logic          ph);
    logic [DW-1:0] sum;
    sum = seed + DW'(idx);
    return ph ? ~sum : sum;
  endfunction

endpackage

// File: rtl/regfile4.sv
// 4-entry register file: one write port, two registered read ports.
// Contents are not reset; a read in the same cycle as a write to the same
// address returns the old contents.
module regfile4 #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] rw,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  // Write port and registered dual read ports
  always_ff @(posedge clk) begin
    if (we) mem_q[rw] <= wdata;
    rdata_a_q <= mem_q[ra];
    rdata_b_q <= mem_q[rb];
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/regfile_bist.sv
// Built-in self-test initiator for regfile4. Two passes (pattern, then its
// complement), each writing all registers before reading them back on both
// ports; records pass/fail and the first failing address.
module regfile_bist #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [AW-1:0] rw,
  output logic          we,
  output logic [DW-1:0] wdata,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  input  logic [DW-1:0] rdata_a,
  input  logic [DW-1:0] rdata_b
);

  import regfile_pkg::*;

  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  bist_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ph_q, ph_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rb_q, rb_d;

  logic [AW-1:0] prev_idx;
  logic [DW-1:0] exp_a, exp_b;
  logic          cmp_en, bad_a, bad_b;

  // Next-state, index, compare and next-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ph_d        = ph_q;
    seed_d      = seed_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;

    // Read data on the ports belongs to the address issued one cycle ago;
    // in DRAIN idx has already wrapped to 0, so idx-1 still names address 3.
    prev_idx = idx_q - AW'(1);
    exp_a    = pat(seed_q, prev_idx, ph_q);
    exp_b    = pat(seed_q, prev_idx ^ LAST, ph_q);
    cmp_en   = ((state_q == ST_READ) && (idx_q != '0)) || (state_q == ST_DRAIN);
    bad_a    = (rdata_a != exp_a);
    bad_b    = (rdata_b != exp_b);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d      = seed;
          pass_d      = 1'b1;
          fail_addr_d = '0;
          ph_d        = 1'b0;
          idx_d       = '0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST) state_d = ST_READ;
      end
      ST_READ: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!ph_q) begin
          ph_d    = 1'b1;
          idx_d   = '0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // pass_q doubles as "no mismatch seen yet", so only the first one lands
    if (cmp_en && pass_q && (bad_a || bad_b)) begin
      pass_d      = 1'b0;
      fail_addr_d = bad_a ? prev_idx : (prev_idx ^ LAST);
    end

    // Port outputs are registered from the next state so nothing is
    // combinational from start/seed to the pins
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    we_d    = (state_d == ST_WRITE);
    rw_d    = we_d ? idx_d : '0;
    wdata_d = we_d ? pat(seed_d, idx_d, ph_d) : '0;
    ra_d    = (state_d == ST_READ) ? idx_d : '0;
    rb_d    = (state_d == ST_READ) ? (idx_d ^ LAST) : '0;
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ph_q        <= 1'b0;
      seed_q      <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      rw_q        <= '0;
      wdata_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      seed_q      <= seed_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign we        = we_q;
  assign rw        = rw_q;
  assign wdata     = wdata_q;
  assign ra        = ra_q;
  assign rb        = rb_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench: regfile_bist wired to regfile4, with an optional stuck-at-1 on bit 0
// of register 2 applied on the read path.
module tb_regfile_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       busy, done, pass, we;
  logic [1:0] fail_addr, rw, ra, rb;
  logic [3:0] wdata, rf_a, rf_b, rdata_a, rdata_b;
  logic [1:0] ra_r = 2'd0, rb_r = 2'd0;
  bit         fault_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] wq[$];
  int         done_t[$];

  always #5 clk = ~clk;

  regfile_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr),
    .rw(rw), .we(we), .wdata(wdata), .ra(ra), .rb(rb),
    .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  regfile4 rf (
    .clk(clk), .we(we), .rw(rw), .wdata(wdata), .ra(ra), .rb(rb),
    .rdata_a(rf_a), .rdata_b(rf_b)
  );

  always @(posedge clk) begin
    ra_r <= ra;
    rb_r <= rb;
    cyc  <= cyc + 1;
  end

  assign rdata_a = rf_a | {3'b000, fault_en && (ra_r == 2'd2)};
  assign rdata_b = rf_b | {3'b000, fault_en && (rb_r == 2'd2)};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tpat(input logic [3:0] s, input int i, input int p);
    logic [3:0] v;
    v = s + i[3:0];
    return (p != 0) ? ~v : v;
  endfunction

  // ---------------- behavioural model ----------------
  // m_k: cycles since the accepting edge (-1 when idle). A run lasts 19
  // cycles (k=0..18) and the following IDLE cycle can accept again.
  int         m_k = -1;
  bit         m_res = 1'b0;
  logic [3:0] m_seed = 4'h0;
  int         m_mk = 99;   // cycle from which the first mismatch is visible
  logic [1:0] m_fa = 2'd0;

  // Register file as the BIST sees it after each pass's writes
  function automatic logic [3:0] mem_rd(input logic [3:0] s, input int i, input int p, input bit f);
    return tpat(s, i, p) | {3'b000, f && (i == 2)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   = -1;
      m_res = 1'b0;
      m_mk  = 99;
      m_fa  = 2'd0;
    end else if (m_k < 0) begin
      if (start) begin
        m_k    = 0;
        m_res  = 1'b1;
        m_seed = seed;
        m_mk   = 99;
        m_fa   = 2'd0;
        for (int p = 0; p < 2; p++) begin
          for (int j = 0; j < 4; j++) begin
            logic [3:0] ga, gb;
            ga = mem_rd(m_seed, j, p, fault_en);
            gb = mem_rd(m_seed, j ^ 3, p, fault_en);
            if (m_mk == 99 && (ga != tpat(m_seed, j, p) || gb != tpat(m_seed, j ^ 3, p))) begin
              m_mk = 6 + j + 9 * p;
              m_fa = (ga != tpat(m_seed, j, p)) ? 2'(j) : 2'(j ^ 3);
            end
          end
        end
      end
    end else if (m_k == 18) begin
      m_k = -1;
    end else begin
      m_k = m_k + 1;
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    int k, kk;
    logic e_we, e_pass;
    logic [1:0] e_rw, e_ra, e_rb, e_fa;
    logic [3:0] e_wd;
    k = m_k;
    e_we = 1'b0; e_rw = 2'd0; e_wd = 4'h0; e_ra = 2'd0; e_rb = 2'd0;
    if (k >= 0 && k <= 3) begin
      e_we = 1'b1; e_rw = 2'(k); e_wd = tpat(m_seed, k, 0);
    end else if (k >= 9 && k <= 12) begin
      e_we = 1'b1; e_rw = 2'(k - 9); e_wd = tpat(m_seed, k - 9, 1);
    end
    if (k >= 4 && k <= 7) begin
      e_ra = 2'(k - 4); e_rb = 2'((k - 4) ^ 3);
    end else if (k >= 13 && k <= 16) begin
      e_ra = 2'(k - 13); e_rb = 2'((k - 13) ^ 3);
    end
    kk = (k < 0) ? 19 : k;
    if (k < 0 && !m_res) begin
      e_pass = 1'b0; e_fa = 2'd0;
    end else if (kk >= m_mk) begin
      e_pass = 1'b0; e_fa = m_fa;
    end else begin
      e_pass = 1'b1; e_fa = 2'd0;
    end
    chk("busy", busy, k >= 0);
    chk("done", done, k == 18);
    chk("we", we, e_we);
    chk("rw", rw, e_rw);
    chk("wdata", wdata, e_wd);
    chk("ra", ra, e_ra);
    chk("rb", rb, e_rb);
    chk("pass", pass, e_pass);
    chk("fail_addr", fail_addr, e_fa);
    if (we) wq.push_back(wdata);
    if (done) done_t.push_back(cyc);
  end

  // One full run with literal expectations on latency, result and write data
  task automatic run_test(input logic [3:0] s, input bit f, input bit ep,
                          input logic [1:0] efa, input logic [31:0] ew);
    int n;
    fault_en = f;
    seed = s;
    wq.delete();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_latency", n, 18);
    chk("lit_pass", pass, ep);
    chk("lit_fail_addr", fail_addr, efa);
    chk("write_count", wq.size(), 8);
    if (wq.size() == 8)
      for (int i = 0; i < 8; i++) chk("write_seq", wq[i], ew[31 - 4 * i -: 4]);
    @(posedge clk); #2;
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    run_test(4'h5, 1'b0, 1'b1, 2'd0, 32'h5678A987);
    run_test(4'hF, 1'b0, 1'b1, 2'd0, 32'hF0120FED);
    run_test(4'h5, 1'b1, 1'b0, 2'd2, 32'h5678A987);

    // start pulses at E3 and E12 are ignored
    fault_en = 1'b0;
    seed = 4'h5;
    done_t.delete();
    start = 1'b1;
    @(posedge clk); #2;
    t0 = cyc;
    start = 1'b0;
    repeat (2) @(posedge clk); #2;
    start = 1'b1; seed = 4'h9;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (15) @(posedge clk); #2;
    chk("pulse_done_count", done_t.size(), 1);
    if (done_t.size() >= 1) chk("pulse_done_time", done_t[0] - t0, 18);

    // asynchronous reset during pass-0 READ
    seed = 4'h5;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ra", ra, 0);
    chk("rst_rb", rb, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    run_test(4'h3, 1'b0, 1'b1, 2'd0, 32'h3456CBA9);

    // back-to-back runs with start held high (faulty regfile)
    fault_en = 1'b1;
    seed = 4'h5;
    done_t.delete();
    start = 1'b1;
    repeat (45) @(posedge clk); #2;
    start = 1'b0;
    repeat (25) @(posedge clk); #2;
    chk("b2b_done_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      chk("b2b_period1", done_t[1] - done_t[0], 20);
      chk("b2b_period2", done_t[2] - done_t[1], 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
